// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the AES-128 round sequencer.
package aes_ctrl_pkg;

    localparam int NUM_ROUNDS_DEF = 10;
    localparam int RND_W_DEF      = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_ROUND = 3'd2,
        ST_FINAL = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Bit positions inside the enable vector {SB,SR,MC,AR,KS}
    localparam int ENB_SB = 4;
    localparam int ENB_SR = 3;
    localparam int ENB_MC = 2;
    localparam int ENB_AR = 1;
    localparam int ENB_KS = 0;

    localparam logic [4:0] ENB_NONE  = 5'b00000;
    localparam logic [4:0] ENB_INIT  = 5'b00010;
    localparam logic [4:0] ENB_ALL   = 5'b11111;
    localparam logic [4:0] ENB_FINAL = 5'b11011;

endpackage

// File: rtl/aes_round_decode.sv
// Combinational map from sequencer state and round count to core controls.
module aes_round_decode
    import aes_ctrl_pkg::*;
#(
    parameter int NUM_ROUNDS = NUM_ROUNDS_DEF,
    parameter int RND_W      = RND_W_DEF
) (
    input  state_e           state_i,
    input  logic [RND_W-1:0] rnd_i,
    output logic             accept_o,
    output logic [RND_W-1:0] rnd_no_o,
    output logic [4:0]       enb_o
);

    always_comb begin
        accept_o = 1'b0;
        rnd_no_o = '0;
        enb_o    = ENB_NONE;
        case (state_i)
            ST_INIT: begin
                accept_o = 1'b1;
                enb_o    = ENB_INIT;
            end
            ST_ROUND: begin
                rnd_no_o = rnd_i;
                enb_o    = ENB_ALL;
            end
            ST_FINAL: begin
                rnd_no_o = RND_W'(NUM_ROUNDS);
                enb_o    = ENB_FINAL;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/aes_round_sequencer.sv
// Steps the iterative AES-128 core through initial AddRoundKey, full rounds and the final round.
//   state | meaning
//   IDLE  | waiting for start, core holds its result
//   INIT  | core loads plain_text ^ key and the raw key
//   ROUND | full round rnd (SB, SR, MC, AR, KS)
//   FINAL | last round, MixColumns skipped
//   DONE  | result valid until out_ack
module aes_round_sequencer
    import aes_ctrl_pkg::*;
#(
    parameter int NUM_ROUNDS = NUM_ROUNDS_DEF,
    parameter int RND_W      = RND_W_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             abort,
    input  logic             out_ack,
    output logic             ready,
    output logic             busy,
    output logic             out_valid,
    output logic             accept,
    output logic [RND_W-1:0] rndNo,
    output logic             enbSB,
    output logic             enbSR,
    output logic             enbMC,
    output logic             enbAR,
    output logic             enbKS
);

    localparam logic [RND_W-1:0] LAST_FULL = RND_W'(NUM_ROUNDS - 1);

    state_e           state_q;
    logic [RND_W-1:0] rnd_q;
    logic [4:0]       enb;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            rnd_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // abort wins over a simultaneous start
                    if (start && !abort) begin
                        state_q <= ST_INIT;
                        rnd_q   <= RND_W'(1);
                    end
                end
                ST_INIT: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                        rnd_q   <= '0;
                    end else begin
                        state_q <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                        rnd_q   <= '0;
                    end else begin
                        rnd_q <= rnd_q + RND_W'(1);
                        if (rnd_q >= LAST_FULL) begin
                            state_q <= ST_FINAL;
                        end
                    end
                end
                ST_FINAL: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                        rnd_q   <= '0;
                    end else begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (abort || out_ack) begin
                        state_q <= ST_IDLE;
                        rnd_q   <= '0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    rnd_q   <= '0;
                end
            endcase
        end
    end

    // Every output is decoded from registers only; illegal encodings decode to all zero.
    assign ready     = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_INIT) || (state_q == ST_ROUND) || (state_q == ST_FINAL);
    assign out_valid = (state_q == ST_DONE);

    aes_round_decode #(
        .NUM_ROUNDS (NUM_ROUNDS),
        .RND_W      (RND_W)
    ) u_decode (
        .state_i  (state_q),
        .rnd_i    (rnd_q),
        .accept_o (accept),
        .rnd_no_o (rndNo),
        .enb_o    (enb)
    );

    assign enbSB = enb[ENB_SB];
    assign enbSR = enb[ENB_SR];
    assign enbMC = enb[ENB_MC];
    assign enbAR = enb[ENB_AR];
    assign enbKS = enb[ENB_KS];

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Sequencer driving a behavioural AES-128 core, checked against a step-level control model and known answers.
module tb_aes_round_sequencer;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

    logic clk = 1'b0, rstn = 1'b0, start = 1'b0, abort = 1'b0, out_ack = 1'b0;
    logic ready, busy, out_valid, accept, enbSB, enbSR, enbMC, enbAR, enbKS;
    logic [3:0] rndNo;
    logic [127:0] pt = '0, key = '0, c_state = '0, c_key = '0, m_expect = '0;
    logic [7:0] sbox_t [256];
    int n_tests = 0, n_fail = 0;
    int m_step = -1;
    int lat;

    always #5 clk = ~clk;

    aes_round_sequencer dut (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort), .out_ack(out_ack),
        .ready(ready), .busy(busy), .out_valid(out_valid), .accept(accept), .rndNo(rndNo),
        .enbSB(enbSB), .enbSR(enbSR), .enbMC(enbMC), .enbAR(enbAR), .enbKS(enbKS)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = '0; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p ^= aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] t;
        t = {x, x} << n;
        return t[15:8];
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] x);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox_t[x[127-8*i -: 8]];
        return o;
    endfunction

    // Byte i of the state is row i%4, column i/4.
    function automatic logic [127:0] shift_rows(input logic [127:0] x);
        logic [127:0] o;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127-8*(r+4*c) -: 8] = x[127-8*(r+4*((c+r)%4)) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] x);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = x[127-32*c -: 8]; a1 = x[119-32*c -: 8];
            a2 = x[111-32*c -: 8]; a3 = x[103-32*c -: 8];
            o[127-32*c -: 8] = gmul(a0, 8'd2) ^ gmul(a1, 8'd3) ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ gmul(a1, 8'd2) ^ gmul(a2, 8'd3) ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'd2) ^ gmul(a3, 8'd3);
            o[103-32*c -: 8] = gmul(a0, 8'd3) ^ a1 ^ a2 ^ gmul(a3, 8'd2);
        end
        return o;
    endfunction

    function automatic logic [127:0] key_exp(input logic [127:0] k, input int rnd);
        logic [31:0] rot, t, n0, n1, n2, n3;
        logic [7:0] rc;
        rot = {k[23:0], k[31:24]};
        rc = 8'h01;
        for (int i = 1; i < rnd; i++) rc = gmul(rc, 8'd2);
        t = {sbox_t[rot[31:24]] ^ rc, sbox_t[rot[23:16]], sbox_t[rot[15:8]], sbox_t[rot[7:0]]};
        n0 = k[127:96] ^ t;
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] p, input logic [127:0] k);
        logic [127:0] s, rk;
        s = p ^ k; rk = k;
        for (int r = 1; r <= 10; r++) begin
            rk = key_exp(rk, r);
            s = shift_rows(sub_bytes(s));
            if (r < 10) s = mix_columns(s);
            s ^= rk;
        end
        return s;
    endfunction

    // Core obeying the datapath contract: a disabled stage passes through, state registered every clk.
    always @(posedge clk) begin : core_model
        logic [127:0] s, k;
        s = accept ? pt : c_state;
        k = accept ? key : c_key;
        if (enbKS) k = key_exp(k, int'(rndNo));
        if (enbSB) s = sub_bytes(s);
        if (enbSR) s = shift_rows(s);
        if (enbMC) s = mix_columns(s);
        if (enbAR) s ^= k;
        c_state <= s;
        c_key   <= k;
    end

    // Step model: -1 idle, 0 initial AddRoundKey, 1..9 full rounds, 10 final round, 11 result valid.
    always @(posedge clk) begin
        if (!rstn) m_step = -1;
        else if (m_step == -1) begin
            if (start && !abort) begin
                m_step   = 0;
                m_expect = aes_ref(pt, key);
            end
        end else if (m_step <= 10) m_step = abort ? -1 : m_step + 1;
        else if (abort || out_ack) m_step = -1;
    end

    always @(negedge clk) begin : monitor
        logic in_run, rnd_stage;
        logic [8:0] exp_f, got_f;
        in_run    = (m_step >= 0) && (m_step <= 10);
        rnd_stage = (m_step >= 1) && (m_step <= 10);
        exp_f = {m_step == -1, in_run, m_step == 11, m_step == 0, rnd_stage, rnd_stage,
                 (m_step >= 1) && (m_step <= 9), in_run, rnd_stage};
        got_f = {ready, busy, out_valid, accept, enbSB, enbSR, enbMC, enbAR, enbKS};
        check("ctrl_flags", 128'(got_f), 128'(exp_f));
        if (in_run) check("rndNo", 128'(rndNo), 128'(m_step));
        if (m_step == 11) check("result", c_state, m_expect);
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_start(input logic [127:0] p, input logic [127:0] k);
        pt = p; key = k; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(input string tag, output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_valid_seen"}, 128'(out_valid), 128'(1));
    endtask

    task automatic ack();
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
        check("ready_after_ack", 128'(ready), 128'(1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check(tag, 128'({ready, busy, out_valid, accept, rndNo, enbSB, enbSR, enbMC, enbAR, enbKS}),
              128'({1'b1, 12'b0}));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end

        tick(2);
        check_reset_outputs("reset_outputs");
        rstn = 1'b1;
        tick();

        // FIPS-197 C.1, latency counted from the sampling edge
        run_start(C1_PT, C1_KEY);
        wait_valid("c1", lat);
        check("c1_latency", 128'(lat), 128'(11));
        check("c1_ct", c_state, C1_CT);
        ack();

        // FIPS-197 App.B with per-cycle trace from the monitor
        run_start(B_PT, B_KEY);
        wait_valid("b", lat);
        check("b_ct", c_state, B_CT);
        ack();

        // Ignored start pulses while busy and while holding the result
        run_start(C1_PT, C1_KEY);
        tick(3);
        start = 1'b1; tick(2); start = 1'b0;
        wait_valid("hold", lat);
        for (int i = 0; i < 20; i++) begin
            start = (i % 3 == 0);
            tick();
        end
        start = 1'b0;
        tick();
        check("hold_valid", 128'(out_valid), 128'(1));
        check("hold_ct", c_state, C1_CT);
        ack();
        run_start(C1_PT, C1_KEY);
        wait_valid("second", lat);
        check("second_ct", c_state, C1_CT);
        ack();

        // Abort mid-run, then immediate restart
        run_start(C1_PT, C1_KEY);
        tick(4);
        abort = 1'b1; tick(); abort = 1'b0;
        check("abort_ready", 128'({ready, busy, out_valid}), 128'(3'b100));
        run_start(B_PT, B_KEY);
        wait_valid("after_abort", lat);
        check("after_abort_ct", c_state, B_CT);
        ack();

        // Reset mid-run
        run_start(B_PT, B_KEY);
        tick(6);
        rstn = 1'b0; tick(); rstn = 1'b1;
        check_reset_outputs("midrun_reset");
        run_start(C1_PT, C1_KEY);
        wait_valid("after_reset", lat);
        check("after_reset_ct", c_state, C1_CT);
        ack();

        // start and abort together in IDLE
        start = 1'b1; abort = 1'b1;
        tick(3);
        check("start_abort_idle", 128'({ready, accept, busy}), 128'(3'b100));
        start = 1'b0; abort = 1'b0;
        tick();

        // Random traffic against the step model
        for (int i = 0; i < 1500; i++) begin
            if (ready) begin
                pt  = {$urandom, $urandom, $urandom, $urandom};
                key = {$urandom, $urandom, $urandom, $urandom};
            end
            start   = ($urandom_range(0, 3) == 0);
            abort   = ($urandom_range(0, 40) == 0);
            out_ack = ($urandom_range(0, 3) == 0);
            rstn    = ($urandom_range(0, 300) != 0);
            tick();
        end
        start = 1'b0; abort = 1'b0; out_ack = 1'b0; rstn = 1'b1;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
